// File: rtl/obstacle_scroll_ctrl.sv
// Per-frame obstacle scroller: steps pos_x left by speed each frame and writes x0/y0 into the sprite core.
// Latency: x0 write 3 cycles after tick, CPU pass-through 1 cycle; CPU slot access stalls FSM writes, nothing dropped.
module obstacle_scroll_ctrl #(
    parameter int FRAME_Y = 480,
    parameter int SPEED_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        ctl_cs,
    input  logic        ctl_write,
    input  logic [2:0]  ctl_addr,
    input  logic [31:0] ctl_wr_data,
    input  logic        cpu_cs,
    input  logic        cpu_write,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic        sp_cs,
    output logic        sp_write,
    output logic [13:0] sp_addr,
    output logic [31:0] sp_wr_data,
    output logic [10:0] pos_x,
    output logic        busy,
    output logic        wrap_pulse
);

    typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

    state_t               state;
    logic                 enable;
    logic [SPEED_W-1:0]   speed;
    logic [10:0]          x_start;
    logic [10:0]          x_end;
    logic [10:0]          y_lane;
    logic                 cond;
    logic                 cond_d;
    logic                 tick;
    logic                 ctl_we;
    logic                 load_pos;
    logic [10:0]          load_val;
    logic [11:0]          wrap_limit;
    logic                 will_wrap;
    logic                 unused_ctl_bits;

    assign cond       = (x == 11'd0) && (y == 11'(FRAME_Y));
    assign tick       = cond & ~cond_d;
    assign ctl_we     = ctl_cs & ctl_write;

    // pos_x reloads on an enable rising edge, or on an x_start write while stopped
    assign load_pos   = ctl_we && !enable &&
                        ((ctl_addr == 3'd0 && ctl_wr_data[0]) || ctl_addr == 3'd2);
    assign load_val   = (ctl_addr == 3'd2) ? ctl_wr_data[10:0] : x_start;

    assign wrap_limit = {1'b0, x_end} + 12'(speed);
    assign will_wrap  = {1'b0, pos_x} < wrap_limit;

    assign unused_ctl_bits = ^ctl_wr_data[31:11];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable  <= 1'b0;
            speed   <= SPEED_W'(1);
            x_start <= 11'd640;
            x_end   <= 11'd0;
            y_lane  <= 11'd0;
            cond_d  <= 1'b0;
        end else begin
            cond_d <= cond;
            if (ctl_we) begin
                case (ctl_addr)
                    3'd0:    enable  <= ctl_wr_data[0];
                    3'd1:    speed   <= ctl_wr_data[SPEED_W-1:0];
                    3'd2:    x_start <= ctl_wr_data[10:0];
                    3'd3:    x_end   <= ctl_wr_data[10:0];
                    3'd4:    y_lane  <= ctl_wr_data[10:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pos_x      <= 11'd0;
            sp_cs      <= 1'b0;
            sp_write   <= 1'b0;
            sp_addr    <= 14'd0;
            sp_wr_data <= 32'd0;
            wrap_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            // CPU owns the slot whenever it selects it; FSM writes below only fire when it doesn't
            if (cpu_cs) begin
                sp_cs      <= 1'b1;
                sp_write   <= cpu_write;
                sp_addr    <= cpu_addr;
                sp_wr_data <= cpu_wr_data;
            end else begin
                sp_cs      <= 1'b0;
                sp_write   <= 1'b0;
                sp_addr    <= 14'd0;
                sp_wr_data <= 32'd0;
            end

            if (load_pos) begin
                pos_x <= load_val;
            end

            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (will_wrap) begin
                        pos_x      <= x_start;
                        wrap_pulse <= 1'b1;
                    end else begin
                        pos_x <= pos_x - 11'(speed);
                    end
                    state <= WR_X;
                end
                WR_X: begin
                    if (!cpu_cs) begin
                        sp_cs      <= 1'b1;
                        sp_write   <= 1'b1;
                        sp_addr    <= 14'h2001;
                        sp_wr_data <= {21'b0, pos_x};
                        state      <= WR_Y;
                    end
                end
                WR_Y: begin
                    if (!cpu_cs) begin
                        sp_cs      <= 1'b1;
                        sp_write   <= 1'b1;
                        sp_addr    <= 14'h2002;
                        sp_wr_data <= {21'b0, y_lane};
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scroll_ctrl.sv
// Bench for obstacle_scroll_ctrl: directed corner sequences, a vector table, and randomized frames vs. a frame-level model.
module tb_obstacle_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        ctl_cs, ctl_write;
    logic [2:0]  ctl_addr;
    logic [31:0] ctl_wr_data;
    logic        cpu_cs, cpu_write;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        sp_cs, sp_write;
    logic [13:0] sp_addr;
    logic [31:0] sp_wr_data;
    logic [10:0] pos_x;
    logic        busy, wrap_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    obstacle_scroll_ctrl #(.FRAME_Y(480), .SPEED_W(4)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .ctl_cs(ctl_cs), .ctl_write(ctl_write), .ctl_addr(ctl_addr), .ctl_wr_data(ctl_wr_data),
        .cpu_cs(cpu_cs), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .sp_cs(sp_cs), .sp_write(sp_write), .sp_addr(sp_addr), .sp_wr_data(sp_wr_data),
        .pos_x(pos_x), .busy(busy), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos_init;
        int x_end;
        int speed;
        int x_start;
        int exp_pos;
        int exp_wrap;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cond(input bit on);
        x = on ? 11'd0 : 11'd5;
        y = on ? 11'd480 : 11'd0;
    endtask

    task automatic ctl_wr(input logic [2:0] a, input logic [31:0] d);
        ctl_cs = 1'b1; ctl_write = 1'b1; ctl_addr = a; ctl_wr_data = d;
        step();
        ctl_cs = 1'b0; ctl_write = 1'b0;
    endtask

    // Drives the frame condition per cycle from pat (bit i = cycle i) and tallies slot writes and wraps.
    task automatic run_seq(input logic [15:0] pat, input int n,
                           output int nx, output int ny, output int nw,
                           output logic [31:0] xd, output logic [31:0] yd);
        nx = 0; ny = 0; nw = 0; xd = '0; yd = '0;
        for (int i = 0; i < n; i++) begin
            set_cond(i < 16 ? pat[i] : 1'b0);
            step();
            if (sp_cs && sp_write && sp_addr == 14'h2001) begin nx++; xd = sp_wr_data; end
            if (sp_cs && sp_write && sp_addr == 14'h2002) begin ny++; yd = sp_wr_data; end
            if (wrap_pulse) nw++;
        end
        set_cond(1'b0);
    endtask

    initial begin
        vec_t        vecs[9];
        int          nx, ny, nw;
        logic [31:0] xd, yd;
        int          m_pos, m_xs, m_xe, m_spd, m_yl, m_wrap;
        logic        p_cs, p_wr;
        logic [13:0] p_addr;
        logic [31:0] p_dat;

        vecs[0] = '{640,    0,  4, 640,  636, 0};
        vecs[1] = '{5,      3,  4, 640,  640, 1};
        vecs[2] = '{7,      3,  4, 600,    3, 0};
        vecs[3] = '{6,      3,  4, 600,  600, 1};
        vecs[4] = '{100,    0,  0, 500,  100, 0};
        vecs[5] = '{0,      0,  0, 500,    0, 0};
        vecs[6] = '{2047, 2040, 15, 123,  123, 1};
        vecs[7] = '{2047, 2030, 15,   9, 2032, 0};
        vecs[8] = '{15,     0, 15,  77,    0, 0};

        reset = 1'b1;
        set_cond(1'b0);
        ctl_cs = 0; ctl_write = 0; ctl_addr = 0; ctl_wr_data = 0;
        cpu_cs = 0; cpu_write = 0; cpu_addr = 0; cpu_wr_data = 0;
        step(); step();
        reset = 1'b0;
        step();

        chk("reset_sp_cs", sp_cs, 0);
        chk("reset_sp_addr", sp_addr, 0);
        chk("reset_pos_x", pos_x, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wrap", wrap_pulse, 0);

        ctl_wr(3'd0, 32'd1);
        chk("enable_loads_pos", pos_x, 640);

        // Nominal frame with speed 4
        ctl_wr(3'd1, 32'd4);
        ctl_wr(3'd4, 32'd37);
        set_cond(1'b1);
        step(); set_cond(1'b0);
        chk("t1_busy", busy, 1);
        chk("t1_sp_cs", sp_cs, 0);
        step();
        chk("t2_wrap", wrap_pulse, 0);
        chk("t2_pos", pos_x, 636);
        step();
        chk("t3_x0", {sp_cs, sp_write, sp_addr, sp_wr_data}, {1'b1, 1'b1, 14'h2001, 32'd636});
        chk("t3_busy", busy, 1);
        step();
        chk("t4_y0", {sp_cs, sp_write, sp_addr, sp_wr_data}, {1'b1, 1'b1, 14'h2002, 32'd37});
        chk("t4_busy", busy, 0);
        step();
        chk("t5_idle_sp", sp_cs, 0);

        // CPU holds the slot for T+1..T+4; FSM writes slip behind it
        set_cond(1'b1);
        step(); set_cond(1'b0);
        cpu_cs = 1; cpu_write = 1; cpu_addr = 14'h2000; cpu_wr_data = 32'd1;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("cpu_hold_mirror", {sp_cs, sp_write, sp_addr, sp_wr_data}, {1'b1, 1'b1, 14'h2000, 32'd1});
        end
        cpu_cs = 0; cpu_write = 0;
        step();
        chk("cpu_hold_x0", {sp_cs, sp_addr, sp_wr_data}, {1'b1, 14'h2001, 32'd632});
        step();
        chk("cpu_hold_y0", {sp_cs, sp_addr, sp_wr_data}, {1'b1, 14'h2002, 32'd37});
        step();

        // Condition held 4 cycles gives one sequence
        run_seq(16'h000F, 10, nx, ny, nw, xd, yd);
        chk("held_cond_nx", nx, 1);
        chk("held_cond_ny", ny, 1);
        chk("held_cond_pos", pos_x, 628);

        // Second tick while busy is dropped
        run_seq(16'h0005, 10, nx, ny, nw, xd, yd);
        chk("busy_drop_nx", nx, 1);
        chk("busy_drop_pos", pos_x, 624);

        // Disable mid-sequence: current writes finish, next frame is ignored
        set_cond(1'b1);
        step(); set_cond(1'b0);
        step();
        ctl_cs = 1; ctl_write = 1; ctl_addr = 3'd0; ctl_wr_data = 32'd0;
        step();
        ctl_cs = 0; ctl_write = 0;
        chk("dis_x0", {sp_cs, sp_addr, sp_wr_data}, {1'b1, 14'h2001, 32'd620});
        step();
        chk("dis_y0", {sp_cs, sp_addr, sp_wr_data}, {1'b1, 14'h2002, 32'd37});
        run_seq(16'h0001, 10, nx, ny, nw, xd, yd);
        chk("dis_next_nx", nx + ny, 0);
        chk("dis_next_pos", pos_x, 620);
        chk("dis_next_busy", busy, 0);

        // Asynchronous reset mid-sequence
        ctl_wr(3'd0, 32'd1);
        chk("reen_pos", pos_x, 640);
        set_cond(1'b1);
        step(); set_cond(1'b0);
        step();
        reset = 1'b1;
        #1;
        chk("arst_sp", {sp_cs, sp_write, sp_addr, sp_wr_data}, 64'd0);
        chk("arst_pos", pos_x, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wrap", wrap_pulse, 0);
        step();
        reset = 1'b0;
        run_seq(16'h0000, 6, nx, ny, nw, xd, yd);
        chk("arst_idle_writes", nx + ny, 0);
        chk("arst_idle_busy", busy, 0);

        // Vector table: one frame step from a chosen start point
        ctl_wr(3'd4, 32'd9);
        foreach (vecs[i]) begin
            ctl_wr(3'd0, 32'd0);
            ctl_wr(3'd2, vecs[i].pos_init);
            ctl_wr(3'd0, 32'd1);
            ctl_wr(3'd2, vecs[i].x_start);
            ctl_wr(3'd3, vecs[i].x_end);
            ctl_wr(3'd1, vecs[i].speed);
            chk("vec_pos_init", pos_x, vecs[i].pos_init);
            run_seq(16'h0001, 10, nx, ny, nw, xd, yd);
            chk("vec_pos", pos_x, vecs[i].exp_pos);
            chk("vec_wrap", nw, vecs[i].exp_wrap);
            chk("vec_x0_data", {nx, xd}, {32'd1, 32'(vecs[i].exp_pos)});
            chk("vec_y0_data", {ny, yd}, {32'd1, 32'd9});
        end

        // Randomized frames with CPU traffic, checked against a frame-level model
        m_xs = $urandom_range(100, 700);
        ctl_wr(3'd0, 32'd0);
        ctl_wr(3'd2, m_xs);
        ctl_wr(3'd0, 32'd1);
        m_pos = m_xs;
        for (int f = 0; f < 40; f++) begin
            m_spd = $urandom_range(0, 15);
            m_xe  = $urandom_range(0, 60);
            m_xs  = $urandom_range(100, 700);
            m_yl  = $urandom_range(0, 2047);
            ctl_wr(3'd1, m_spd);
            ctl_wr(3'd3, m_xe);
            ctl_wr(3'd2, m_xs);
            ctl_wr(3'd4, m_yl);
            ctl_wr(3'd5, $urandom);
            nx = 0; ny = 0; nw = 0; xd = '0; yd = '0;
            p_cs = 0; p_wr = 0; p_addr = '0; p_dat = '0;
            for (int i = 0; i < 16; i++) begin
                set_cond(i == 0);
                cpu_cs      = (i < 7) && ($urandom_range(0, 2) == 0);
                cpu_write   = 1'($urandom);
                cpu_addr    = 14'($urandom_range(0, 14'h1FFF));
                cpu_wr_data = $urandom;
                p_cs = cpu_cs; p_wr = cpu_write; p_addr = cpu_addr; p_dat = cpu_wr_data;
                step();
                if (p_cs) begin
                    chk("rnd_cpu_mirror", {sp_cs, sp_write, sp_addr, sp_wr_data}, {1'b1, p_wr, p_addr, p_dat});
                end else if (sp_cs) begin
                    if (sp_addr == 14'h2001) begin nx++; xd = sp_wr_data; end
                    else if (sp_addr == 14'h2002) begin ny++; yd = sp_wr_data; end
                    else nx += 100;
                end
                if (wrap_pulse) nw++;
            end
            cpu_cs = 0; cpu_write = 0;
            set_cond(1'b0);
            m_wrap = (m_pos < m_xe + m_spd) ? 1 : 0;
            m_pos  = m_wrap ? m_xs : m_pos - m_spd;
            chk("rnd_pos", pos_x, m_pos);
            chk("rnd_x0", {nx, xd}, {32'd1, 32'(m_pos)});
            chk("rnd_y0", {ny, yd}, {32'd1, 32'(m_yl)});
            chk("rnd_wrap", nw, m_wrap);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
